// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding and default sizes for the FIR front-end
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } fir_state_t;

  localparam int TAP_SIZE  = 2;
  localparam int X_N_SIZE  = 8;
  localparam int Y_N_SIZE  = 10;
  localparam int FLUSH_LEN = 5;
  localparam int PIPE_LAT  = 2;

endpackage

// File: rtl/fir_valid_pipe.sv
// rtl/fir_valid_pipe.sv - PIPE_LAT-deep valid shift register with synchronous clear
module fir_valid_pipe #(
  parameter int PIPE_LAT = fir_pkg::PIPE_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  output logic tail
);

  logic [PIPE_LAT-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | PIPE_LAT'(push);
    end
  end

  assign tail = sr[PIPE_LAT-1];

endmodule

// File: rtl/fir_cfg_sequencer.sv
// rtl/fir_cfg_sequencer.sv - shares the FIR input bus between coefficient loads and samples,
// flushes the delay line after each load and re-times the FIR output with a valid flag
module fir_cfg_sequencer #(
  parameter int NBR_OF_TAPS = 3,
  parameter int TAP_SIZE    = fir_pkg::TAP_SIZE,
  parameter int X_N_SIZE    = fir_pkg::X_N_SIZE,
  parameter int Y_N_SIZE    = fir_pkg::Y_N_SIZE,
  parameter int FLUSH_LEN   = fir_pkg::FLUSH_LEN,
  parameter int PIPE_LAT    = fir_pkg::PIPE_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [X_N_SIZE-1:0] cfg_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [X_N_SIZE-1:0] s_data,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_set_coeffs,
  output logic                fir_tvalid,
  input  logic [Y_N_SIZE-1:0] fir_y_n,
  output logic                y_valid,
  output logic [Y_N_SIZE-1:0] y_data,
  output logic                busy,
  output logic                cfg_err
);
  import fir_pkg::*;

  localparam int CNT_W   = $clog2(NBR_OF_TAPS + 1);
  localparam int FLUSH_W = $clog2(FLUSH_LEN + 1);
  localparam logic [CNT_W-1:0]   LAST_TAP   = CNT_W'(NBR_OF_TAPS - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_LEN - 1);

  // The FIR takes its coefficient from the low TAP_SIZE bits of the shared bus.
  if (TAP_SIZE < 1 || TAP_SIZE > X_N_SIZE) begin : g_bad_tap_size
    $error("TAP_SIZE must fit inside the X_N_SIZE bus");
  end

  fir_state_t          state, state_n;
  logic [CNT_W-1:0]    coef_cnt, coef_cnt_n, coef_base;
  logic [FLUSH_W-1:0]  flush_cnt, flush_cnt_n;
  logic [X_N_SIZE-1:0] x_n_n;
  logic                set_n, tvalid_n, err_n;
  logic                accept, pipe_clear, pipe_tail;

  always_comb begin
    state_n     = state;
    coef_cnt_n  = coef_cnt;
    flush_cnt_n = flush_cnt;
    x_n_n       = fir_x_n;
    set_n       = 1'b0;
    tvalid_n    = 1'b0;
    err_n       = cfg_err;
    accept      = 1'b0;
    pipe_clear  = 1'b0;
    // A restart inside LOAD makes the same-cycle beat coefficient 0.
    coef_base   = cfg_start ? '0 : coef_cnt;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          state_n    = ST_LOAD;
          coef_cnt_n = '0;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_LOAD: begin
        coef_cnt_n = coef_base;
        err_n      = cfg_err | cfg_start;
        if (cfg_valid && cfg_ready) begin
          set_n = 1'b1;
          x_n_n = cfg_data;
          if (coef_base == LAST_TAP) begin
            state_n     = ST_FLUSH;
            flush_cnt_n = '0;
          end else begin
            coef_cnt_n = coef_base + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (cfg_start) begin
          state_n    = ST_LOAD;
          coef_cnt_n = '0;
          err_n      = 1'b1;
        end else begin
          tvalid_n    = 1'b1;
          x_n_n       = '0;
          flush_cnt_n = flush_cnt + FLUSH_W'(1);
          if (flush_cnt == LAST_FLUSH) state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_start) begin
          state_n    = ST_LOAD;
          coef_cnt_n = '0;
          pipe_clear = 1'b1;
        end else if (s_valid && s_ready) begin
          accept   = 1'b1;
          tvalid_n = 1'b1;
          x_n_n    = s_data;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      coef_cnt       <= '0;
      flush_cnt      <= '0;
      fir_x_n        <= '0;
      fir_set_coeffs <= 1'b0;
      fir_tvalid     <= 1'b0;
      cfg_ready      <= 1'b0;
      s_ready        <= 1'b0;
      busy           <= 1'b0;
      cfg_err        <= 1'b0;
      y_valid        <= 1'b0;
      y_data         <= '0;
    end else begin
      state          <= state_n;
      coef_cnt       <= coef_cnt_n;
      flush_cnt      <= flush_cnt_n;
      fir_x_n        <= x_n_n;
      fir_set_coeffs <= set_n;
      fir_tvalid     <= tvalid_n;
      cfg_ready      <= (state_n == ST_LOAD);
      s_ready        <= (state_n == ST_RUN);
      busy           <= (state_n == ST_LOAD) || (state_n == ST_FLUSH);
      cfg_err        <= err_n;
      y_valid        <= pipe_tail && !pipe_clear;
      if (pipe_tail && !pipe_clear) y_data <= fir_y_n;
    end
  end

  fir_valid_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .reset(reset),
    .clear(pipe_clear),
    .push (accept),
    .tail (pipe_tail)
  );

endmodule
